// File: rtl/wb_lcd_fifo.sv
// Wishbone slave feeding an HD44780-style character LCD from a command/data FIFO.
// A single down-counter times setup, enable pulse, hold and execute-wait phases.
module wb_lcd_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter bit BUS4       = 1'b0,
    parameter int T_SETUP    = 4,
    parameter int T_EPW      = 25,
    parameter int T_HOLD     = 4,
    parameter int T_EXEC     = 2500,
    parameter int T_LONG     = 82000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_data,
    output logic        irq
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int TM1  = (T_SETUP > T_EPW) ? T_SETUP : T_EPW;
    localparam int TM2  = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int TM3  = (TM1 > TM2) ? TM1 : TM2;
    localparam int TMAX = (TM3 > T_LONG) ? TM3 : T_LONG;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EPW   = CW'(T_EPW - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(T_LONG - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EHI,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            cnt_zero;
    logic            pop;
    logic            nib_load;
    logic            low_nib;
    logic            long_cmd;
    logic [7:0]      entry_data;

    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [LW-1:0]   level;
    logic [8:0]      rd_entry;
    logic            empty;
    logic            full;

    logic            ack_reg;
    logic            access;
    logic            wr;
    logic [1:0]      reg_sel;
    logic            push_req;
    logic            push;
    logic            flush;
    logic            ovf_clr;
    logic            overflow;
    logic            irq_en;
    logic            busy;
    logic [31:0]     rdata;
    logic            unused_bits;

    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:8]};

    assign access   = wb_stb_i & wb_cyc_i & ~ack_reg;
    assign wr       = access & wb_we_i & wb_sel_i[0];
    assign reg_sel  = wb_adr_i[3:2];
    assign push_req = wr & (reg_sel == 2'd0 || reg_sel == 2'd1);
    assign flush    = wr & (reg_sel == 2'd3) & wb_dat_i[1];
    assign ovf_clr  = wr & (reg_sel == 2'd2) & wb_dat_i[3];

    assign empty    = (level == '0);
    assign full     = (level == LW'(FIFO_DEPTH));
    // Full is judged on the pre-edge level, so a same-edge pop never makes room.
    assign push     = push_req & ~full;
    assign rd_entry = mem[rptr];
    assign busy     = (state != ST_IDLE);

    assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_reg;
    assign lcd_rw   = 1'b0;

    // FIFO storage: DATA (reg 0) carries rs=1, CMD (reg 1) carries rs=0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {~reg_sel[0], wb_dat_i[7:0]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd2:    rdata = {16'h0000, 8'(level), 4'h0, overflow, full, empty, busy};
            2'd3:    rdata = {31'h0, irq_en};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_reg  <= 1'b0;
            wb_dat_o <= '0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            ack_reg <= access;
            if (access) begin
                wb_dat_o <= rdata;
            end
            if (wr && reg_sel == 2'd3) begin
                irq_en <= wb_dat_i[0];
            end
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            irq <= irq_en & empty & ~busy;
        end
    end

    assign cnt_zero = (cnt == '0);
    assign long_cmd = ~lcd_rs & (entry_data == 8'h01 || entry_data == 8'h02 || entry_data == 8'h03);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        nib_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_next = ST_SETUP;
                    cnt_next   = LD_SETUP;
                    pop        = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_next = ST_EHI;
                    cnt_next   = LD_EPW;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_EHI: begin
                if (cnt_zero) begin
                    state_next = ST_HOLD;
                    cnt_next   = LD_HOLD;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    // In 4-bit mode the high nibble goes first, then the low nibble.
                    if (BUS4 && !low_nib) begin
                        state_next = ST_SETUP;
                        cnt_next   = LD_SETUP;
                        nib_load   = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = long_cmd ? LD_LONG : LD_EXEC;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            entry_data <= rd_entry[7:0];
        end
    end

    // Enable is registered from the next state so it tracks EHI exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
            low_nib  <= 1'b0;
        end else begin
            lcd_e <= (state_next == ST_EHI);
            if (pop) begin
                lcd_rs   <= rd_entry[8];
                lcd_data <= BUS4 ? {rd_entry[7:4], 4'h0} : rd_entry[7:0];
                low_nib  <= 1'b0;
            end else if (nib_load) begin
                lcd_data <= {entry_data[3:0], 4'h0};
                low_nib  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_lcd_fifo.sv
// Scoreboard bench for wb_lcd_fifo: an 8-bit bus instance and a 4-bit bus instance
// share clock and reset; expected LCD strobes and read data are queued and popped by monitors.
module tb_wb_lcd_fifo;

    localparam int TS = 2;
    localparam int TE = 3;
    localparam int TH = 2;
    localparam int TX = 10;
    localparam int TL = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          cycnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic        stb8 = 0, cyc8 = 0, we8 = 0;
    logic [31:0] adr8 = 0, dat8 = 0;
    logic [3:0]  sel8 = 0;
    logic [31:0] rdat8;
    logic        ack8, rs8, rw8, e8, irq8;
    logic [7:0]  data8;

    logic        stb4 = 0, cyc4 = 0, we4 = 0;
    logic [31:0] adr4 = 0, dat4 = 0;
    logic [3:0]  sel4 = 0;
    logic [31:0] rdat4;
    logic        ack4, rs4, rw4, e4, irq4;
    logic [7:0]  data4;

    logic [8:0]  q8[$];
    logic [8:0]  q4[$];
    logic [31:0] rd_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycnt <= cycnt + 1;

    wb_lcd_fifo #(.FIFO_DEPTH(16), .BUS4(1'b0), .T_SETUP(TS), .T_EPW(TE), .T_HOLD(TH),
                  .T_EXEC(TX), .T_LONG(TL)) u8 (
        .clk(clk), .reset(reset), .wb_stb_i(stb8), .wb_cyc_i(cyc8), .wb_we_i(we8),
        .wb_adr_i(adr8), .wb_sel_i(sel8), .wb_dat_i(dat8), .wb_dat_o(rdat8), .wb_ack_o(ack8),
        .lcd_rs(rs8), .lcd_rw(rw8), .lcd_e(e8), .lcd_data(data8), .irq(irq8));

    wb_lcd_fifo #(.FIFO_DEPTH(16), .BUS4(1'b1), .T_SETUP(TS), .T_EPW(TE), .T_HOLD(TH),
                  .T_EXEC(TX), .T_LONG(TL)) u4 (
        .clk(clk), .reset(reset), .wb_stb_i(stb4), .wb_cyc_i(cyc4), .wb_we_i(we4),
        .wb_adr_i(adr4), .wb_sel_i(sel4), .wb_dat_i(dat4), .wb_dat_o(rdat4), .wb_ack_o(ack4),
        .lcd_rs(rs4), .lcd_rw(rw4), .lcd_e(e4), .lcd_data(data4), .irq(irq4));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycnt);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: output presented with nothing queued (cycle %0d)", name, cycnt);
    endtask

    task automatic wait_cyc(input int n);
        if (cycnt > n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL schedule: at cycle %0d, required cycle %0d", cycnt, n);
        end
        while (cycnt < n) @(negedge clk);
    endtask

    // One access: acked on the edge after driving; released right after the clearing edge.
    task automatic bus(input bit on4, input bit we, input logic [1:0] adr,
                       input logic [31:0] dat, output int k);
        if (on4) begin
            stb4 = 1; cyc4 = 1; we4 = we; adr4 = {28'h0, adr, 2'b00}; sel4 = 4'h1; dat4 = dat;
        end else begin
            stb8 = 1; cyc8 = 1; we8 = we; adr8 = {28'h0, adr, 2'b00}; sel8 = 4'h1; dat8 = dat;
        end
        @(posedge clk);
        #1;
        k = cycnt;
        @(negedge clk);
        chk("wb_ack", on4 ? ack4 : ack8, 1);
        @(posedge clk);
        #1;
        stb4 = 0; cyc4 = 0; we4 = 0; sel4 = 0;
        stb8 = 0; cyc8 = 0; we8 = 0; sel8 = 0;
    endtask

    task automatic rd(input logic [1:0] adr, input logic [31:0] exp);
        int k;
        rd_q.push_back(exp);
        bus(0, 0, adr, 32'h0, k);
    endtask

    task automatic drain8();
        int t;
        t = 0;
        while (q8.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", (q8.size() == 0) ? 32'd1 : 32'd0, 1);
        repeat (60) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset && ack8 && !we8) begin
            if (rd_q.size() == 0) unexpected("wb_read");
            else chk("wb_read", rdat8, rd_q.pop_front());
        end
    end

    logic       prev8 = 0, prev4 = 0;
    int         hi8 = 0, hi4 = 0;
    logic [8:0] ex8, ex4;

    always @(negedge clk) begin
        if (!reset) begin
            prev8 <= 0;
            hi8   <= 0;
        end else begin
            if (e8 && !prev8) begin
                chk("lcd_rw8", rw8, 0);
                if (q8.size() == 0) unexpected("lcd_entry8");
                else begin
                    ex8 = q8.pop_front();
                    chk("lcd_entry8", {rs8, data8}, ex8);
                end
            end
            if (e8) hi8 <= hi8 + 1;
            else if (prev8) begin
                chk("e_width8", hi8, TE);
                hi8 <= 0;
            end
            prev8 <= e8;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            prev4 <= 0;
            hi4   <= 0;
        end else begin
            if (e4 && !prev4) begin
                if (q4.size() == 0) unexpected("lcd_entry4");
                else begin
                    ex4 = q4.pop_front();
                    chk("lcd_entry4", {rs4, data4}, ex4);
                end
            end
            if (e4) hi4 <= hi4 + 1;
            else if (prev4) begin
                chk("e_width4", hi4, TE);
                hi4 <= 0;
            end
            prev4 <= e4;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, k2, m, kk, j;
        bit  lowok;

        repeat (3) @(negedge clk);
        chk("rst_e8", e8, 0);
        chk("rst_rs8", rs8, 0);
        chk("rst_data8", data8, 0);
        chk("rst_ack8", ack8, 0);
        chk("rst_irq8", irq8, 0);
        chk("rst_dat_o8", rdat8, 0);
        chk("rst_e4", e4, 0);
        chk("rst_data4", data4, 0);
        reset = 1;
        @(negedge clk);
        rd(2'd2, 32'h2);

        // Reset asserted mid-EHI drops E immediately.
        q8.push_back({1'b1, 8'h55});
        bus(0, 1, 2'd0, 32'h55, k);
        wait_cyc(k + 4);
        chk("e_before_reset", e8, 1);
        #2 reset = 0;
        #1;
        chk("e_async_reset", e8, 0);
        chk("data_async_reset", data8, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        rd(2'd2, 32'h2);

        // Single DATA 0x41 on the 8-bit bus.
        q8.push_back({1'b1, 8'h41});
        bus(0, 1, 2'd0, 32'h41, k);
        wait_cyc(k + 1);
        chk("rs_k1", rs8, 1);
        chk("data_k1", data8, 8'h41);
        chk("e_k1", e8, 0);
        wait_cyc(k + 2);
        chk("e_k2", e8, 0);
        wait_cyc(k + 3);
        chk("e_k3", e8, 1);
        wait_cyc(k + 17);
        rd(2'd2, 32'h3);
        rd(2'd2, 32'h2);

        // Clear command takes the long wait; next entry starts one idle cycle later.
        q8.push_back({1'b0, 8'h01});
        q8.push_back({1'b1, 8'h48});
        bus(0, 1, 2'd1, 32'h01, k);
        bus(0, 1, 2'd0, 32'h48, k2);
        wait_cyc(k + 3);
        chk("clr_e", e8, 1);
        chk("clr_rs", rs8, 0);
        wait_cyc(k + 47);
        rd(2'd2, 32'h0101);
        wait_cyc(k + 50);
        chk("second_e_k50", e8, 0);
        chk("second_data", data8, 8'h48);
        chk("second_rs", rs8, 1);
        wait_cyc(k + 51);
        chk("second_e_k51", e8, 1);

        // 4-bit bus: high nibble then low nibble.
        q4.push_back({1'b1, 8'hA0});
        q4.push_back({1'b1, 8'h50});
        bus(1, 1, 2'd0, 32'hA5, k);
        wait_cyc(k + 1);
        chk("nib_hi_data", data4, 8'hA0);
        chk("nib_hi_rs", rs4, 1);
        wait_cyc(k + 3);
        chk("nib_hi_e", e4, 1);
        wait_cyc(k + 9);
        chk("nib_lo_data", data4, 8'h50);
        chk("nib_lo_e_k9", e4, 0);
        wait_cyc(k + 10);
        chk("nib_lo_e_k10", e4, 1);
        chk("nib_lo_rs", rs4, 1);

        drain8();

        // Overflow: FSM occupied by a clear; 17 pushes, the last is dropped.
        q8.push_back({1'b0, 8'h01});
        bus(0, 1, 2'd1, 32'h01, m);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) begin
                q8.push_back({1'b1, 8'(8'h30 + i)});
                bus(0, 1, 2'd0, 32'(8'h30 + i), kk);
            end else begin
                bus(0, 1, 2'd0, 32'h7F, kk);
            end
        end
        rd(2'd2, 32'h100D);
        bus(0, 1, 2'd2, 32'h8, kk);
        rd(2'd2, 32'h1005);
        drain8();
        rd(2'd2, 32'h2);

        // Interrupt on drain.
        bus(0, 1, 2'd3, 32'h1, kk);
        rd(2'd3, 32'h1);
        chk("irq_idle_en", irq8, 1);
        q8.push_back({1'b1, 8'h61});
        q8.push_back({1'b1, 8'h62});
        bus(0, 1, 2'd0, 32'h61, k);
        bus(0, 1, 2'd0, 32'h62, kk);
        lowok = 1;
        for (int c = k + 3; c <= k + 36; c++) begin
            wait_cyc(c);
            if (irq8 !== 1'b0) lowok = 0;
        end
        chk("irq_low_busy", lowok, 1);
        wait_cyc(k + 37);
        chk("irq_after_idle", irq8, 1);

        // Flush during a transfer: the in-flight entry completes, the queued one is discarded.
        q8.push_back({1'b1, 8'h71});
        bus(0, 1, 2'd0, 32'h71, j);
        bus(0, 1, 2'd0, 32'h72, kk);
        bus(0, 1, 2'd3, 32'h3, kk);
        rd(2'd3, 32'h1);
        rd(2'd2, 32'h3);
        wait_cyc(j + 18);
        chk("irq_flush_busy", irq8, 0);
        wait_cyc(j + 19);
        chk("irq_flush_done", irq8, 1);

        drain8();
        rd(2'd2, 32'h2);
        @(negedge clk);
        chk("q4_left", q4.size(), 0);
        chk("rd_left", rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_lcd_fifo.md
# wb_lcd_fifo

Wishbone slave that drives an HD44780-compatible character LCD through a buffered command/data queue and a cycle-exact bus-timing engine. It is the parametrised successor of the single-register LCD peripheral. Software pushes characters and commands into a FIFO without polling. The block serialises each entry onto the LCD bus in 8-bit or 4-bit mode, with a longer execute wait for clear/home commands, and raises an interrupt when the queue drains.

## Interface
- `FIFO_DEPTH`, 16: queue entries; power of two, 2..128.
- `BUS4`, 0: 0 = 8-bit LCD bus; 1 = 4-bit bus (high nibble first, on `lcd_data[7:4]`).
- `T_SETUP`, 4: cycles RS/data are stable before E rises.
- `T_EPW`, 25: cycles E is held high.
- `T_HOLD`, 4: cycles RS/data are held after E falls.
- `T_EXEC`, 2500: wait cycles after a normal entry.
- `T_LONG`, 82000: wait cycles after command 0x01, 0x02 or 0x03.
- `clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-low.
- `wb_stb_i`, `wb_cyc_i`, `wb_we_i` in 1: Wishbone strobe, cycle and write-enable.
- `wb_adr_i` in 32: only bits [3:2] are decoded.
- `wb_sel_i` in 4: a write takes effect only if bit 0 is set.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: registered read data.
- `wb_ack_o` out 1: `stb & cyc & ack_reg`.
- `lcd_rs`, `lcd_rw`, `lcd_e` out 1: LCD control. `lcd_rw` is always 0.
- `lcd_data` out 8: LCD data. In 4-bit mode bits [3:0] are 0.
- `irq` out 1: level interrupt.

## Operation
- Register map, selected by `wb_adr_i[3:2]`:
  - 0 DATA. Write pushes `{rs=1, wb_dat_i[7:0]}`. Reads return 0.
  - 1 CMD. Write pushes `{rs=0, wb_dat_i[7:0]}`. Reads return 0.
  - 2 STATUS. Read fields: [0] busy (FSM not IDLE), [1] empty, [2] full, [3] overflow (sticky), [15:8] level. Writing 1 to bit 3 clears overflow.
  - 3 CTRL. R/W field [0] irq_en. Writing 1 to bit 1 flushes the FIFO; that bit always reads 0. A flush does not abort the entry in flight.
- Wishbone handshake:
  - `ack_reg` rises on the first edge where `stb & cyc & ~ack_reg`, and is cleared the following edge.
  - Each access therefore takes 1 wait state and gets exactly one ack.
  - The push or register update happens on that same first edge.
- Push while full: the entry is dropped, overflow is set, and the access is still acked. Full is evaluated on the pre-edge level; a pop on the same edge does not make room.
- Simultaneous push and pop: the level is unchanged.
- Flush on the same edge as a push: flush wins and the level becomes 0.
- FSM states and transitions:
  - IDLE → SETUP when the FIFO is non-empty; pops the entry and latches `lcd_rs` and `lcd_data`.
  - SETUP (T_SETUP cycles) → EHI (T_EPW cycles, `lcd_e`=1) → HOLD (T_HOLD cycles).
  - In BUS4 mode after the first nibble, HOLD → SETUP with the low nibble.
  - Otherwise HOLD → WAIT. WAIT lasts T_LONG cycles if rs=0 and data ∈ {0x01, 0x02, 0x03}, else T_EXEC cycles.
  - WAIT → IDLE.
- A single down-counter, wide enough for T_LONG, times every state. Each state loads its count minus 1 on entry and exits on 0.
- In IDLE, `lcd_e`=0 and `lcd_rs`/`lcd_data` keep their last values.
- `irq = irq_en & empty & ~busy`, registered.

## Timing
- Reset (asynchronous, `reset`=0) immediately forces:
  - `lcd_e`=`lcd_rs`=`lcd_rw`=0, `lcd_data`=0;
  - `wb_dat_o`=0, `ack_reg`=0 (so `wb_ack_o`=0), `irq`=0;
  - FIFO empty, overflow=0, irq_en=0, FSM in IDLE.
- Reset mid-transfer aborts it: E drops at once and no wait is completed.
- Latency:
  - A push acked at edge k is popped at edge k+1 if the FSM is idle.
  - `lcd_e` rises at edge k+1+T_SETUP.
- 8-bit entry: occupies the bus for T_SETUP+T_EPW+T_HOLD+T_EXEC (or +T_LONG) cycles.
- 4-bit entry: adds a second T_SETUP+T_EPW+T_HOLD before the wait.
- Back-to-back entries: SETUP of the next entry starts 1 cycle after WAIT ends (the IDLE cycle).
- Level width is clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.

## Test plan
Bench overrides: T_SETUP=2, T_EPW=3, T_HOLD=2, T_EXEC=10, T_LONG=40.
- Reset: hold `reset` low mid-EHI. Required: `lcd_e`=0 in the same cycle; STATUS reads 0x0000_0002 after release.
- DATA write 0x41: `lcd_rs`=1 and `lcd_data`=0x41 from edge k+1; `lcd_e` high exactly 3 cycles; busy for 17 cycles total.
- CMD 0x01 then DATA 0x48: the wait after the clear is 40 cycles. The second SETUP starts 1 cycle after that wait ends.
- BUS4=1, DATA 0xA5: two E pulses with `lcd_data`=0xA0, then 0x50; RS=1 on both.
- Push 17 entries back-to-back with the FSM stalled in WAIT: level reads 16, then full and overflow set; the 17th entry is never emitted. Writing STATUS 0x8 clears overflow.
- Enable irq, push 2 entries: `irq`=0 while busy. `irq`=1 one cycle after the final WAIT returns to IDLE. A flush during a transfer leaves `irq` low until that transfer finishes.
